lcd_fb_writer: RTL

Write side of the 480x320 RGB565 framebuffer. Decodes an already-synchronised 8080/DBI-style LCD bus write stream (commands CASET 0x2A, PASET 0x2B, RAMWR 0x2C, RAMWRC 0x3C) and emits framebuffer write address, data and write-enable. It feeds the framebuffer RAM write port, and the display-side reader scans the same RAM. The address layout is linear row-major: address = y*FB_H + x.

---
 rtl/lcd_fb_pkg.sv | 44 ++++
 rtl/lcd_fb_writer_if.sv | 35 +++
 rtl/lcd_fb_cursor.sv | 79 +++++++
 rtl/lcd_fb_writer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/lcd_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_fb_pkg
// Purpose  : Shared definitions for the LCD framebuffer write path. This
//            package holds the DBI command codes, the default framebuffer
//            geometry, the decoder state encoding and a constant-multiply
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lcd_fb_pkg;

  // DBI command codes; only i_data[7:0] is decoded on a command strobe
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;

  // Default framebuffer geometry (RGB565, 480x320, row-major)
  localparam int FB_H_DEF   = 480;
  localparam int FB_V_DEF   = 320;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CASET_P = 2'd1,
    ST_PASET_P = 2'd2,
    ST_RAMWR   = 2'd3
  } fb_state_t;

  // Multiply by a constant using shifted adds of the constant's set bits.
  // This is only used when the line width has no hand-tuned form.
  function automatic logic [31:0] mul_const(input logic [15:0] v, input int unsigned k);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) acc = acc + (32'(v) << i);
    end
    return acc;
  endfunction

endpackage : lcd_fb_pkg
`default_nettype wire

// File: rtl/lcd_fb_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_fb_writer_if
// Purpose  : Bundles the synchronised DBI write stream and the framebuffer
//            write port for lcd_fb_writer.
// Signals  : i_wr_strobe/i_dc/i_data  - bus write stream (into the decoder)
//            o_write_address/o_write_data/o_write_enable - RAM write port
//            o_frame_start            - pulse on accepted RAMWR
// Modports : slave  - the decoder (consumes the bus, drives the RAM port)
//            master - the bus source / RAM-side observer
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_fb_writer_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              i_wr_strobe;
  logic              i_dc;
  logic [DATA_W-1:0] i_data;
  logic [ADDR_W-1:0] o_write_address;
  logic [DATA_W-1:0] o_write_data;
  logic              o_write_enable;
  logic              o_frame_start;

  modport slave (
    input  i_wr_strobe, i_dc, i_data,
    output o_write_address, o_write_data, o_write_enable, o_frame_start
  );

  modport master (
    output i_wr_strobe, i_dc, i_data,
    input  o_write_address, o_write_data, o_write_enable, o_frame_start
  );
endinterface : lcd_fb_writer_if
`default_nettype wire

// File: rtl/lcd_fb_cursor.sv
`default_nettype none
// ============================================================================
// Module   : lcd_fb_cursor
// Purpose  : Pixel cursor for the framebuffer writer. It holds x, y and the
//            linear row base (y*FB_H), and it walks the active window with
//            column and row wrap.
// Ports    : i_clk, i_rst_n        - clock, synchronous active-low reset
//            i_load                - jump to window origin (RAMWR)
//            i_advance             - step one pixel
//            i_sc/i_ec/i_sp/i_ep   - active window bounds
//            o_x, o_y, o_row_base  - current cursor
// Revision : 1.0 - initial release
// ============================================================================
module lcd_fb_cursor
  import lcd_fb_pkg::*;
#(
  parameter int FB_H   = FB_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RB_W   = ADDR_W + 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_advance,
  input  logic [15:0]     i_sc,
  input  logic [15:0]     i_ec,
  input  logic [15:0]     i_sp,
  input  logic [15:0]     i_ep,
  output logic [15:0]     o_x,
  output logic [15:0]     o_y,
  output logic [RB_W-1:0] o_row_base
);

  logic [15:0]     r_x;
  logic [15:0]     r_y;
  logic [RB_W-1:0] r_row_base;
  logic [RB_W-1:0] w_sp_mul;

  // The start page times the line width is formed without a multiplier.
  // Two extra bits above the RAM address keep rows beyond the panel distinct.
  generate
    if (FB_H == 480) begin : g_mul_480
      assign w_sp_mul = (RB_W'(i_sp) << 9) - (RB_W'(i_sp) << 5);
    end else begin : g_mul_generic
      assign w_sp_mul = RB_W'(mul_const(i_sp, FB_H));
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x        <= 16'd0;
      r_y        <= 16'd0;
      r_row_base <= '0;
    end else if (i_load) begin
      r_x        <= i_sc;
      r_y        <= i_sp;
      r_row_base <= w_sp_mul;
    end else if (i_advance) begin
      if (r_x == i_ec) begin
        r_x <= i_sc;
        if (r_y == i_ep) begin
          r_y        <= i_sp;
          r_row_base <= w_sp_mul;
        end else begin
          r_y        <= r_y + 16'd1;
          r_row_base <= r_row_base + RB_W'(FB_H);
        end
      end else begin
        r_x <= r_x + 16'd1;
      end
    end
  end

  assign o_x        = r_x;
  assign o_y        = r_y;
  assign o_row_base = r_row_base;

endmodule : lcd_fb_cursor
`default_nettype wire

// File: rtl/lcd_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_fb_writer
// Purpose  : Write side of the RGB565 framebuffer. It decodes the DBI
//            commands CASET/PASET/RAMWR/RAMWRC, captures the window
//            parameters and turns pixel data strobes into single-cycle RAM
//            writes at address y*FB_H + x.
// Ports    : i_clk    - clock
//            i_rst_n  - synchronous active-low reset
//            bus      - lcd_fb_writer_if.slave (bus stream in, RAM port out)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_fb_writer
  import lcd_fb_pkg::*;
#(
  parameter int FB_H   = FB_H_DEF,
  parameter int FB_V   = FB_V_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  lcd_fb_writer_if.slave bus
);

  localparam int RB_W = ADDR_W + 2;

  fb_state_t r_state, w_state_nxt;

  logic [1:0]        r_pcnt;
  logic [15:0]       r_shadow;     // start value being assembled
  logic [7:0]        r_end_hi;     // end high byte, joined with 4th byte
  logic [15:0]       r_sc, r_ec, r_sp, r_ep;

  logic              r_we;
  logic              r_fs;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_cmd;
  logic              w_dat;
  logic              w_in_param;
  logic              w_load;
  logic              w_adv;
  logic              w_we_nxt;
  logic              w_fs_nxt;
  logic              w_in_range;
  logic [15:0]       w_end;
  logic [15:0]       w_x, w_y;
  logic [RB_W-1:0]   w_row_base;
  logic [RB_W-1:0]   w_addr_full;

  assign w_cmd      = bus.i_wr_strobe && !bus.i_dc;
  assign w_dat      = bus.i_wr_strobe &&  bus.i_dc;
  assign w_in_param = (r_state == ST_CASET_P) || (r_state == ST_PASET_P);
  assign w_end      = {r_end_hi, bus.i_data[7:0]};

  // Pixels outside the panel still move the cursor, but they never reach RAM
  assign w_in_range  = (w_x < 16'(FB_H)) && (w_y < 16'(FB_V));
  assign w_addr_full = w_row_base + RB_W'(w_x);

  lcd_fb_cursor #(
    .FB_H   (FB_H),
    .ADDR_W (ADDR_W),
    .RB_W   (RB_W)
  ) u_cursor (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_advance  (w_adv),
    .i_sc       (r_sc),
    .i_ec       (r_ec),
    .i_sp       (r_sp),
    .i_ep       (r_ep),
    .o_x        (w_x),
    .o_y        (w_y),
    .o_row_base (w_row_base)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // A command strobe always wins and restarts decoding from scratch
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_we_nxt    = 1'b0;
    w_fs_nxt    = 1'b0;
    if (w_cmd) begin
      case (bus.i_data[7:0])
        CMD_CASET:  w_state_nxt = ST_CASET_P;
        CMD_PASET:  w_state_nxt = ST_PASET_P;
        CMD_RAMWR: begin
          w_state_nxt = ST_RAMWR;
          w_load      = 1'b1;
          w_fs_nxt    = 1'b1;
        end
        CMD_RAMWRC: w_state_nxt = ST_RAMWR;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end else if (w_dat) begin
      case (r_state)
        ST_CASET_P, ST_PASET_P: begin
          if (r_pcnt == 2'd3) w_state_nxt = ST_IDLE;
        end
        ST_RAMWR: begin
          w_adv    = 1'b1;
          w_we_nxt = w_in_range;
        end
        default: ;
      endcase
    end
  end

  // Parameter bytes arrive as start_hi, start_lo, end_hi, end_lo. The
  // window is committed only on the 4th byte and only if it is well-ordered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pcnt   <= 2'd0;
      r_shadow <= 16'd0;
      r_end_hi <= 8'd0;
      r_sc     <= 16'd0;
      r_ec     <= 16'(FB_H - 1);
      r_sp     <= 16'd0;
      r_ep     <= 16'(FB_V - 1);
    end else if (w_cmd) begin
      r_pcnt <= 2'd0;
    end else if (w_dat && w_in_param) begin
      r_pcnt <= r_pcnt + 2'd1;
      case (r_pcnt)
        2'd0: r_shadow[15:8] <= bus.i_data[7:0];
        2'd1: r_shadow[7:0]  <= bus.i_data[7:0];
        2'd2: r_end_hi       <= bus.i_data[7:0];
        default: begin
          if (r_shadow <= w_end) begin
            if (r_state == ST_CASET_P) begin
              r_sc <= r_shadow;
              r_ec <= w_end;
            end else begin
              r_sp <= r_shadow;
              r_ep <= w_end;
            end
          end
        end
      endcase
    end
  end

  // RAM port registers: one-cycle latency from the pixel strobe
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_fs    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_we_nxt;
      r_fs <= w_fs_nxt;
      if (w_adv) begin
        r_addr  <= w_addr_full[ADDR_W-1:0];
        r_wdata <= bus.i_data;
      end
    end
  end

  assign bus.o_write_address = r_addr;
  assign bus.o_write_data    = r_wdata;
  assign bus.o_write_enable  = r_we;
  assign bus.o_frame_start   = r_fs;

endmodule : lcd_fb_writer
`default_nettype wire
